// File: rtl/alu_resp_checker.sv
`default_nettype none
// ============================================================================
// Module      : alu_resp_checker
// Description : Recomputes 4-bit ALU results in a 2-stage pipe, counts
//               pass/fail beats and captures the first mismatching beat.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_resp_checker #(
    parameter int W            = 4,
    parameter int CW           = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [2:0]    in_sel,
    input  logic [W:0]    in_outp,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic          err,
    output logic [1:0]    state,
    output logic          mm_valid,
    output logic [W-1:0]  mm_a,
    output logic [W-1:0]  mm_b,
    output logic [2:0]    mm_sel,
    output logic [W:0]    mm_outp,
    output logic [W:0]    mm_exp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   sel;
        logic [W:0]   outp;
    } beat_t;

    state_t        state_q, state_d;
    logic          s1_vld_q, s1_vld_d;
    beat_t         s1_q, s1_d;
    logic          s2_vld_q, s2_vld_d;
    beat_t         s2_q, s2_d;
    logic [W:0]    s2_exp_q, s2_exp_d;
    logic          s2_match_q, s2_match_d;
    logic [CW-1:0] pass_q, pass_d;
    logic [CW-1:0] fail_q, fail_d;
    logic          err_q, err_d;
    logic          mm_valid_q, mm_valid_d;
    beat_t         mm_q, mm_d;
    logic [W:0]    mm_exp_q, mm_exp_d;

    logic [W:0]    exp_s1;
    logic [W:0]    a_ext;
    logic [W:0]    b_ext;
    logic          commit_fail;
    logic          halt_now;
    logic          accept;

    // Reference ALU, evaluated on the beat held in stage 1.
    always_comb begin
        exp_s1 = '0;
        a_ext  = {1'b0, s1_q.a};
        b_ext  = {1'b0, s1_q.b};
        case (s1_q.sel)
            3'b000: exp_s1 = a_ext + b_ext;
            3'b001: exp_s1 = a_ext - b_ext;
            3'b010: exp_s1 = a_ext & b_ext;
            3'b011: exp_s1 = a_ext | b_ext;
            3'b100: exp_s1 = a_ext ^ b_ext;
            3'b101: exp_s1 = {1'b0, ~s1_q.a};
            3'b110: exp_s1 = {s1_q.a, 1'b0};
            3'b111: exp_s1 = a_ext >> 1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        s1_vld_d    = 1'b0;
        s1_d        = s1_q;
        s2_vld_d    = 1'b0;
        s2_d        = s2_q;
        s2_exp_d    = s2_exp_q;
        s2_match_d  = s2_match_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        err_d       = err_q;
        mm_valid_d  = mm_valid_q;
        mm_d        = mm_q;
        mm_exp_d    = mm_exp_q;

        commit_fail = s2_vld_q && !s2_match_q;
        // Halting flushes everything not yet committed, including this edge's input.
        halt_now    = commit_fail && (STOP_ON_FAIL != 0);
        accept      = in_valid && (state_q != ST_HALT) && !halt_now;

        if (accept) begin
            s1_vld_d = 1'b1;
            s1_d     = {in_a, in_b, in_sel, in_outp};
        end

        if (s1_vld_q && !halt_now) begin
            s2_vld_d   = 1'b1;
            s2_d       = s1_q;
            s2_exp_d   = exp_s1;
            s2_match_d = (exp_s1 == s1_q.outp);
        end

        if (s2_vld_q) begin
            if (s2_match_q) begin
                if (pass_q != {CW{1'b1}}) pass_d = pass_q + 1'b1;
            end else begin
                if (fail_q != {CW{1'b1}}) fail_d = fail_q + 1'b1;
                err_d = 1'b1;
                if (!mm_valid_q) begin
                    mm_valid_d = 1'b1;
                    mm_d       = s2_q;
                    mm_exp_d   = s2_exp_q;
                end
            end
        end

        if (halt_now) begin
            state_d = ST_HALT;
        end else if (accept && (state_q == ST_IDLE)) begin
            state_d = ST_RUN;
        end

        if (clr) begin
            state_d    = ST_IDLE;
            s1_vld_d   = 1'b0;
            s1_d       = '0;
            s2_vld_d   = 1'b0;
            s2_d       = '0;
            s2_exp_d   = '0;
            s2_match_d = 1'b0;
            pass_d     = '0;
            fail_d     = '0;
            err_d      = 1'b0;
            mm_valid_d = 1'b0;
            mm_d       = '0;
            mm_exp_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s1_vld_q   <= 1'b0;
            s1_q       <= '0;
            s2_vld_q   <= 1'b0;
            s2_q       <= '0;
            s2_exp_q   <= '0;
            s2_match_q <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            err_q      <= 1'b0;
            mm_valid_q <= 1'b0;
            mm_q       <= '0;
            mm_exp_q   <= '0;
        end else begin
            state_q    <= state_d;
            s1_vld_q   <= s1_vld_d;
            s1_q       <= s1_d;
            s2_vld_q   <= s2_vld_d;
            s2_q       <= s2_d;
            s2_exp_q   <= s2_exp_d;
            s2_match_q <= s2_match_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            mm_valid_q <= mm_valid_d;
            mm_q       <= mm_d;
            mm_exp_q   <= mm_exp_d;
        end
    end

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;
    assign state    = state_q;
    assign mm_valid = mm_valid_q;
    assign mm_a     = mm_q.a;
    assign mm_b     = mm_q.b;
    assign mm_sel   = mm_q.sel;
    assign mm_outp  = mm_q.outp;
    assign mm_exp   = mm_exp_q;

endmodule
`default_nettype wire
